// File: rtl/sdram_req_frontend_if.sv
// Request/command/refresh bundle between the fabric, the request front-end and
// the SDRAM controller. The slave modport is the front-end's view.
interface sdram_req_frontend_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             InitDone;
    logic             ReqValid;
    logic             ReqReady;
    logic             ReqWrEn;
    logic [24:0]      ReqAddr;
    logic [15:0]      ReqWrData;
    logic [1:0]       ReqByteEn;
    logic             CtrlValid;
    logic             CtrlReady;
    logic             CtrlWrEn;
    logic [1:0]       CtrlBank;
    logic [12:0]      CtrlRow;
    logic [9:0]       CtrlCol;
    logic [15:0]      CtrlWrData;
    logic [1:0]       CtrlDqm;
    logic             RefReq;
    logic             RefAck;
    logic [CNT_W-1:0] FifoCount;
    logic             RefOverrun;

    modport slave (
        input  InitDone, ReqValid, ReqWrEn, ReqAddr, ReqWrData, ReqByteEn,
               CtrlReady, RefAck,
        output ReqReady, CtrlValid, CtrlWrEn, CtrlBank, CtrlRow, CtrlCol,
               CtrlWrData, CtrlDqm, RefReq, FifoCount, RefOverrun
    );

    modport master (
        output InitDone, ReqValid, ReqWrEn, ReqAddr, ReqWrData, ReqByteEn,
               CtrlReady, RefAck,
        input  ReqReady, CtrlValid, CtrlWrEn, CtrlBank, CtrlRow, CtrlCol,
               CtrlWrData, CtrlDqm, RefReq, FifoCount, RefOverrun
    );
endinterface

// File: rtl/sdram_req_frontend.sv
// SDRAM request front-end: queues fabric requests, decodes them into bank/row/col
// commands and arbitrates them against periodic auto-refresh (refresh wins).
module sdram_req_frontend #(
    parameter int DEPTH        = 4,
    parameter int REFRESH_RATE = 1560,
    parameter int MAX_PEND     = 7
) (
    input logic                 Clk,
    input logic                 RstN,
    sdram_req_frontend_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(REFRESH_RATE);
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    localparam logic [1:0] WAIT_INIT = 2'd0;
    localparam logic [1:0] ARB       = 2'd1;
    localparam logic [1:0] REQ_HOLD  = 2'd2;
    localparam logic [1:0] REF_HOLD  = 2'd3;

    typedef struct packed {
        logic        wrEn;
        logic [24:0] addr;
        logic [15:0] wrData;
        logic [1:0]  byteEn;
    } ReqEntry;

    ReqEntry            mem [DEPTH];
    ReqEntry            head;
    logic [1:0]         state;
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   count;
    logic [TMR_W-1:0]   timer;
    logic [PEND_W-1:0]  pend;
    logic               overrun;
    logic               push;
    logic               pop;
    logic               tick;
    logic               ackTaken;

    assign bus.ReqReady   = (count != CNT_W'(DEPTH));
    assign push           = bus.ReqValid && bus.ReqReady;
    assign bus.CtrlValid  = (state == REQ_HOLD);
    assign pop            = bus.CtrlValid && bus.CtrlReady;
    assign bus.RefReq     = (state == REF_HOLD);
    assign ackTaken       = bus.RefAck && bus.RefReq;
    assign tick           = (state != WAIT_INIT) && (timer == TMR_W'(REFRESH_RATE - 1));
    assign bus.FifoCount  = count;
    assign bus.RefOverrun = overrun;

    // Storage carries data only; pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        if (push) mem[wrPtr] <= '{bus.ReqWrEn, bus.ReqAddr, bus.ReqWrData, bus.ReqByteEn};
    end

    // Head fields are forced to zero outside REQ_HOLD so the bus is quiet in reset/idle.
    assign head           = mem[rdPtr];
    assign bus.CtrlWrEn   = head.wrEn & bus.CtrlValid;
    assign bus.CtrlRow    = head.addr[24:12] & {13{bus.CtrlValid}};
    assign bus.CtrlBank   = head.addr[11:10] & {2{bus.CtrlValid}};
    assign bus.CtrlCol    = head.addr[9:0] & {10{bus.CtrlValid}};
    assign bus.CtrlWrData = head.wrData & {16{bus.CtrlValid}};
    assign bus.CtrlDqm    = ~head.byteEn & {2{bus.CtrlValid}};

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ARB always costs one cycle between grants, capping throughput at 1 per 2.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= WAIT_INIT;
        end else begin
            case (state)
                WAIT_INIT: if (bus.InitDone) state <= ARB;
                ARB: begin
                    if (pend != '0)       state <= REF_HOLD;
                    else if (count != '0) state <= REQ_HOLD;
                end
                REQ_HOLD:  if (bus.CtrlReady) state <= ARB;
                REF_HOLD:  if (bus.RefAck)    state <= ARB;
                default:   state <= WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            timer <= '0;
        end else if (state != WAIT_INIT) begin
            timer <= tick ? '0 : timer + TMR_W'(1);
        end
    end

    // A lost tick at saturation is remembered until reset.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else if (tick && !ackTaken) begin
            if (pend == PEND_W'(MAX_PEND)) overrun <= 1'b1;
            else                            pend    <= pend + PEND_W'(1);
        end else if (ackTaken && !tick) begin
            pend <= pend - PEND_W'(1);
        end
    end
endmodule

// File: tb/tb_sdram_req_frontend.sv
// Scoreboard bench for sdram_req_frontend: directed scenarios plus random traffic,
// checked by a monitor against a queue/arithmetic model of the request and refresh rules.
module tb_sdram_req_frontend;
    localparam int DEPTH = 4;
    localparam int RATE  = 16;
    localparam int MAXP  = 7;

    typedef struct packed {
        logic        wrEn;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic [15:0] data;
        logic [1:0]  dqm;
    } cmd_t;

    logic Clk  = 1'b0;
    logic RstN = 1'b0;
    int checks   = 0;
    int failures = 0;

    cmd_t expQ[$];
    bit   mInit, mOver, mTick, mAck, expReady;
    int   mSince, mPend, curPend, lastPend;
    bit   lastCV, lastCR, lastRR;
    cmd_t cur, lastFields;

    always #5 Clk = ~Clk;

    sdram_req_frontend_if #(.DEPTH(DEPTH)) bus ();

    sdram_req_frontend #(
        .DEPTH(DEPTH),
        .REFRESH_RATE(RATE),
        .MAX_PEND(MAXP)
    ) dut (
        .Clk(Clk),
        .RstN(RstN),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected command from a request, by plain address arithmetic.
    function automatic cmd_t decode(input logic wrEn, input logic [24:0] addr,
                                    input logic [15:0] data, input logic [1:0] be);
        cmd_t c;
        int a;
        a      = int'(addr);
        c.wrEn = wrEn;
        c.row  = 13'(a / 4096);
        c.bank = 2'((a / 1024) % 4);
        c.col  = 10'(a % 1024);
        c.data = data;
        c.dqm  = 2'(3 - int'(be));
        return c;
    endfunction

    function automatic cmd_t dutFields();
        cmd_t c;
        c.wrEn = bus.CtrlWrEn;
        c.bank = bus.CtrlBank;
        c.row  = bus.CtrlRow;
        c.col  = bus.CtrlCol;
        c.data = bus.CtrlWrData;
        c.dqm  = bus.CtrlDqm;
        return c;
    endfunction

    // Monitor / scoreboard: observes between edges, predicts the next edge.
    always @(negedge Clk) begin
        if (!RstN) begin
            check("rst_ctrl_valid", bus.CtrlValid, 0);
            check("rst_ref_req", bus.RefReq, 0);
            check("rst_fifo_count", bus.FifoCount, 0);
            check("rst_req_ready", bus.ReqReady, 1);
            check("rst_fields", dutFields(), 0);
            check("rst_overrun", bus.RefOverrun, 0);
            expQ.delete();
            mInit = 0; mOver = 0; mSince = 0; mPend = 0; lastPend = 0;
            lastCV = 0; lastCR = 0; lastRR = 0;
        end else begin
            cur     = dutFields();
            curPend = mPend;
            check("fifo_count", bus.FifoCount, expQ.size());
            expReady = (expQ.size() != DEPTH);
            check("req_ready", bus.ReqReady, expReady);
            check("overrun", bus.RefOverrun, mOver);
            check("valid_ref_exclusive", bus.CtrlValid && bus.RefReq, 0);
            if (!mInit) check("quiet_before_init", {bus.CtrlValid, bus.RefReq}, 0);
            if (bus.CtrlValid && !lastCV) check("cmd_only_without_pending", lastPend, 0);
            if (bus.RefReq && !lastRR) check("ref_only_with_pending", lastPend != 0, 1);
            if (lastCV && !lastCR) begin
                check("valid_held", bus.CtrlValid, 1);
                check("fields_held", cur, lastFields);
            end
            if (bus.CtrlValid && bus.CtrlReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_empty: command 0x%0h issued, none expected", cur);
                end else begin
                    check("cmd_fields", cur, expQ.pop_front());
                end
            end
            if (bus.ReqValid && expReady)
                expQ.push_back(decode(bus.ReqWrEn, bus.ReqAddr, bus.ReqWrData, bus.ReqByteEn));
            mAck = bus.RefAck && bus.RefReq;
            if (!mInit) begin
                if (bus.InitDone) begin
                    mInit  = 1;
                    mSince = 0;
                end
            end else begin
                mSince++;
                mTick = (mSince % RATE) == 0;
                if (mTick && !mAck) begin
                    if (mPend == MAXP) mOver = 1;
                    else               mPend++;
                end else if (mAck && !mTick) begin
                    mPend--;
                end
            end
            lastPend = curPend; lastCV = bus.CtrlValid; lastCR = bus.CtrlReady;
            lastRR = bus.RefReq; lastFields = cur;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.ReqValid = 0; bus.ReqWrEn = 0; bus.ReqAddr = '0; bus.ReqWrData = '0;
        bus.ReqByteEn = '0; bus.CtrlReady = 0; bus.RefAck = 0;
    endtask

    task automatic doReset();
        idleInputs();
        bus.InitDone = 0;
        RstN = 0;
        step();
        step();
        RstN = 1;
    endtask

    task automatic pushReq(input logic wrEn, input logic [24:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
        bus.ReqValid = 1; bus.ReqWrEn = wrEn; bus.ReqAddr = addr;
        bus.ReqWrData = data; bus.ReqByteEn = be;
        step();
        bus.ReqValid = 0;
    endtask

    task automatic waitHigh(input string name, input bit wantRef, input int maxCyc);
        int n = 0;
        while ((wantRef ? bus.RefReq : bus.CtrlValid) !== 1'b1 && n < maxCyc) begin
            step();
            n++;
        end
        check(name, wantRef ? bus.RefReq : bus.CtrlValid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idleInputs();
        bus.InitDone = 0;
        #2;
        doReset();

        // Fill the FIFO before init: nothing may issue.
        for (int i = 0; i < 4; i++)
            pushReq(1'($urandom), 25'($urandom), 16'($urandom), 2'($urandom));
        check("full_ready", bus.ReqReady, 0);
        check("full_count", bus.FifoCount, 4);
        check("full_no_valid", bus.CtrlValid, 0);
        bus.InitDone = 1;
        bus.CtrlReady = 1;
        n = 0;
        while ((bus.FifoCount != 0 || bus.CtrlValid) && n < 40) begin step(); n++; end
        check("init_drain_count", bus.FifoCount, 0);

        // Decode and two-cycle latency.
        doReset();
        bus.InitDone = 1;
        step();
        bus.InitDone = 0;
        step();
        bus.CtrlReady = 1;
        pushReq(1'b1, 25'h1ABCDEF, 16'hA5A5, 2'b01);
        check("latency_cycle1", bus.CtrlValid, 0);
        step();
        check("latency_cycle2", bus.CtrlValid, 1);
        check("dec_row", bus.CtrlRow, 13'h1ABC);
        check("dec_bank", bus.CtrlBank, 2'd3);
        check("dec_col", bus.CtrlCol, 10'h1EF);
        check("dec_dqm", bus.CtrlDqm, 2'b10);
        check("dec_data", bus.CtrlWrData, 16'hA5A5);
        check("dec_wren", bus.CtrlWrEn, 1);
        step();

        // Stall in REQ_HOLD across a refresh tick.
        bus.CtrlReady = 0;
        pushReq(1'b0, 25'h0123456, 16'h1234, 2'b11);
        waitHigh("stall_valid_rise", 0, 4);
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_no_refreq", bus.RefReq, 0);
        end
        bus.CtrlReady = 1;
        step();
        bus.CtrlReady = 0;
        waitHigh("ref_after_handshake", 1, 4);
        bus.RefAck = 1;
        step();
        bus.RefAck = 0;

        // Saturation, overrun, coincident tick/ack, queued request behind refresh.
        doReset();
        bus.InitDone = 1;
        step();
        bus.InitDone = 0;
        repeat (8 * RATE - 1) step();
        check("overrun_before_8th", bus.RefOverrun, 0);
        step();
        check("overrun_at_8th", bus.RefOverrun, 1);
        check("refreq_saturated", bus.RefReq, 1);
        pushReq(1'b1, 25'h1FFFFFF, 16'hBEEF, 2'b10);
        bus.RefAck = 1;
        step();
        bus.RefAck = 0;
        waitHigh("ref_again_after_ack", 1, 3);
        check("req_waits_for_refresh", bus.CtrlValid, 0);
        n = 0;
        while (!((mSince + 1) % RATE == 0) && n < 2 * RATE) begin step(); n++; end
        check("coincident_ref_held", bus.RefReq, 1);
        bus.RefAck = 1;
        step();
        bus.RefAck = 0;
        n = 0;
        while (!bus.CtrlValid && n < 200) begin
            bus.RefAck = bus.RefReq;
            step();
            n++;
        end
        bus.RefAck = 0;
        check("req_after_last_ack", bus.CtrlValid, 1);
        bus.CtrlReady = 1;
        step();
        bus.CtrlReady = 0;

        // Asynchronous reset during REQ_HOLD.
        doReset();
        bus.InitDone = 1;
        step();
        for (int i = 0; i < 3; i++)
            pushReq(1'($urandom), 25'($urandom), 16'($urandom), 2'($urandom));
        waitHigh("hold_before_reset", 0, 4);
        #2;
        RstN = 0;
        #1;
        check("async_valid_low", bus.CtrlValid, 0);
        check("async_refreq_low", bus.RefReq, 0);
        check("async_count_zero", bus.FifoCount, 0);
        bus.InitDone = 0;
        step();
        step();
        RstN = 1;
        pushReq(1'b0, 25'h0000400, 16'h0F0F, 2'b00);
        repeat (5) step();
        check("back_in_wait_init", bus.CtrlValid, 0);
        check("queued_after_reset", bus.FifoCount, 1);
        bus.InitDone = 1;

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.ReqValid  = 1'($urandom);
            bus.ReqWrEn   = 1'($urandom);
            bus.ReqAddr   = 25'($urandom);
            bus.ReqWrData = 16'($urandom);
            bus.ReqByteEn = 2'($urandom);
            bus.CtrlReady = ($urandom_range(0, 2) != 0);
            bus.RefAck    = bus.RefReq ? 1'($urandom) : ($urandom_range(0, 7) == 0);
            bus.InitDone  = 1'($urandom);
            step();
        end
        bus.ReqValid  = 0;
        bus.CtrlReady = 1;
        n = 0;
        while ((expQ.size() != 0 || bus.CtrlValid) && n < 300) begin
            bus.RefAck = bus.RefReq;
            step();
            n++;
        end
        bus.RefAck = 0;
        check("drain_empty", bus.FifoCount, 0);
        check("drain_scoreboard", expQ.size(), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_req_frontend.md
SDRAM_REQ_FRONTEND -- requirements
Module: sdram_req_frontend

Interface
REQ-001 The block SHALL have one clock, Clk; its reset, RstN, SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH, 4, request FIFO entries (power of two, 2..16).
REQ-003 Parameter REFRESH_RATE, 1560, cycles between refresh ticks.
REQ-004 Parameter MAX_PEND, 7, saturation limit of the pending-refresh counter.
REQ-005 Clk  in  1  clock.
REQ-006 RstN  in  1  asynchronous active-low reset.
REQ-007 InitDone  in  1  SDRAM controller has finished power-up initialization.
REQ-008 ReqValid  in  1  fabric request valid.
REQ-009 ReqReady  out  1  FIFO can accept a request.
REQ-010 ReqWrEn  in  1  1 = write, 0 = read.
REQ-011 ReqAddr  in  25  16-bit-word address.
REQ-012 ReqWrData  in  16  write data.
REQ-013 ReqByteEn  in  2  byte enables, active-high.
REQ-014 CtrlValid  out  1  command to the controller valid.
REQ-015 CtrlReady  in  1  controller accepts the command.
REQ-016 CtrlWrEn, CtrlBank[1:0], CtrlRow[12:0], CtrlCol[9:0], CtrlWrData[15:0], CtrlDqm[1:0]  out  command fields.
REQ-017 RefReq  out  1  auto-refresh request to the controller.
REQ-018 RefAck  in  1  one-cycle pulse: refresh taken.
REQ-019 FifoCount  out  log2(DEPTH)+1  occupancy.
REQ-020 RefOverrun  out  1  sticky flag: refresh tick lost.

Function
REQ-021 Push SHALL occur on a rising edge where ReqValid && ReqReady; ReqReady SHALL equal (FifoCount != DEPTH), independent of same-cycle pops.
REQ-022 Pop SHALL occur on a rising edge where CtrlValid && CtrlReady; push and pop in the same cycle SHALL leave FifoCount unchanged, and read/write pointers SHALL wrap modulo DEPTH.
REQ-023 Field decode from the FIFO head SHALL be: CtrlRow = Addr[24:12], CtrlBank = Addr[11:10], CtrlCol = Addr[9:0], CtrlDqm = ~ByteEn; CtrlWrData and CtrlWrEn SHALL be passed through unchanged, including on reads.
REQ-024 The FSM SHALL have states WAIT_INIT, ARB, REQ_HOLD and REF_HOLD.
REQ-025 WAIT_INIT SHALL move to ARB on the first edge with InitDone=1; InitDone SHALL be ignored in every other state.
REQ-026 ARB SHALL move to REF_HOLD if the pending count is not 0, else to REQ_HOLD if the FIFO is not empty, else stay in ARB; refresh SHALL have priority.
REQ-027 REQ_HOLD SHALL drive CtrlValid=1 with stable head fields until CtrlReady, then pop and return to ARB; CtrlValid SHALL never drop without a handshake.
REQ-028 REF_HOLD SHALL drive RefReq=1 until RefAck, then return to ARB; RefAck outside REF_HOLD SHALL be ignored.
REQ-029 CtrlValid and RefReq SHALL never both be 1.
REQ-030 A refresh timer SHALL count only while not in WAIT_INIT and SHALL emit a tick every REFRESH_RATE cycles, with the first tick REFRESH_RATE cycles after leaving WAIT_INIT.
REQ-031 The pending count SHALL update as follows:
- +1 per tick;
- -1 per accepted RefAck;
- a tick and a RefAck in the same cycle SHALL leave it unchanged;
- a tick at MAX_PEND without a RefAck SHALL leave it at MAX_PEND and set RefOverrun until reset.
REQ-032 Latency: a request pushed into an empty FIFO with the FSM in ARB and no refresh pending SHALL raise CtrlValid in the second cycle after the push edge.
REQ-033 Throughput SHALL be at most one command per two cycles because of the ARB bubble.

Reset
REQ-034 While RstN=0 the block SHALL hold: FSM in WAIT_INIT; FIFO empty; FifoCount=0; ReqReady=1; CtrlValid=0; RefReq=0; all Ctrl fields 0; timer=0; pending=0; RefOverrun=0.
REQ-035 Reset asserted mid-operation SHALL immediately deassert CtrlValid and RefReq and discard all queued requests.

Verification
REQ-036 Reset, InitDone=0, push 4 requests -> ReqReady=0 after the 4th; CtrlValid stays 0; FifoCount=4.
REQ-037 InitDone=1, write Addr=0x1ABCDEF, ByteEn=2'b01, Data=0xA5A5, CtrlReady=1 -> CtrlRow=0x1ABC, CtrlBank=3, CtrlCol=0x1EF, CtrlDqm=2'b10, CtrlValid 2 cycles after the push.
REQ-038 CtrlReady held 0 for 10 cycles during REQ_HOLD -> CtrlValid and the fields remain stable; a refresh tick in that window does not raise RefReq until after the handshake.
REQ-039 REFRESH_RATE=16, RefAck never given -> pending reaches 7 after 112 cycles and RefOverrun=1 at the 8th tick; a later RefAck drops pending to 6 on the next edge.
REQ-040 Tick coincident with RefAck -> pending unchanged; a queued request waits while pending is not 0 and is issued after the last RefAck.
REQ-041 RstN pulsed low during REQ_HOLD with 3 entries queued -> CtrlValid=0 asynchronously, FifoCount=0, FSM returns to WAIT_INIT.
